// File: rtl/edge_pkg.sv
// Shared definitions for the dual-edge event controller: edge polarity
// encodings and the channel-index width helper.
package edge_pkg;

    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

    // Width of a channel index for n channels; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dual_edge_sampler.sv
// Per-channel dual-edge sampler. Remembers the previous level and a primed
// flag so that the level present at reset release never looks like an edge.
module dual_edge_sampler
    import edge_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sig,
    input  logic en,
    output logic edge_pulse,
    output logic level
);

    logic prev;
    logic primed;

    // Track the input every cycle; the first clock after reset only primes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev   <= 1'b0;
            primed <= 1'b0;
        end else begin
            prev   <= sig;
            primed <= 1'b1;
        end
    end

    // An edge is any level change once primed; disabling masks the report
    // but prev keeps tracking, so re-enabling never invents an edge.
    assign edge_pulse = primed & en & (sig != prev);
    assign level      = sig ? EVT_RISE : EVT_FALL;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel dual-edge event controller. Each channel keeps one pending
// event (newest polarity wins, overrun flagged) and a round-robin arbiter
// shares one registered event output between channels.
//
// Handshake: evt_valid/evt_chan/evt_rise are registered. An event transfers
// at a posedge where evt_valid & evt_ready. While evt_valid & !evt_ready the
// payload is held stable and no new grant is made. The output slot is free
// (may load a new event or drop valid) whenever !evt_valid | evt_ready.
module edge_event_arbiter
    import edge_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = chan_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  sig,
    input  logic [N-1:0]  en,
    input  logic [N-1:0]  ovr_clr,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [CW-1:0] evt_chan,
    output logic          evt_rise,
    output logic [N-1:0]  pending,
    output logic [N-1:0]  overrun
);

    logic [N-1:0]  edge_vec;
    logic [N-1:0]  level_vec;
    logic [N-1:0]  pend;
    logic [N-1:0]  pol;
    logic [N-1:0]  gnt_vec;
    logic [CW-1:0] rr_last;
    logic [CW-1:0] gnt_idx;
    logic          gnt_any;
    logic          slot_free;

    for (genvar i = 0; i < N; i++) begin : g_ch
        dual_edge_sampler u_sampler (
            .clk        (clk),
            .reset      (reset),
            .sig        (sig[i]),
            .en         (en[i]),
            .edge_pulse (edge_vec[i]),
            .level      (level_vec[i])
        );
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        slot_free = !evt_valid || evt_ready;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (slot_free && !gnt_any && pend[(int'(rr_last) + k) % N]) begin
                gnt_any = 1'b1;
                gnt_idx = CW'((int'(rr_last) + k) % N);
            end
        end
    end

    // One-hot view of the grant, used to clear the winning pending bit.
    always_comb begin
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // Pending/polarity/overrun bookkeeping; a new edge always beats a grant
    // clear, and an overrun set beats an ovr_clr on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend    <= '0;
            pol     <= '0;
            overrun <= '0;
        end else begin
            pend    <= (pend & ~gnt_vec) | edge_vec;
            pol     <= (pol & ~edge_vec) | (level_vec & edge_vec);
            overrun <= (overrun & ~ovr_clr) | (edge_vec & pend & ~gnt_vec);
        end
    end

    // Output register: load the granted event or go idle when the slot frees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            evt_rise  <= EVT_FALL;
            rr_last   <= CW'(N - 1);
        end else if (slot_free) begin
            evt_valid <= gnt_any;
            if (gnt_any) begin
                evt_chan <= gnt_idx;
                evt_rise <= pol[gnt_idx];
                rr_last  <= gnt_idx;
            end
        end
    end

    assign pending = pend;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed stimulus pushes expected events
// into a queue; a monitor pops and compares on every accepted handshake.
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int W  = CW + 1;

    logic          clk;
    logic          reset;
    logic [N-1:0]  sig;
    logic [N-1:0]  en;
    logic [N-1:0]  ovr_clr;
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_chan;
    logic          evt_rise;
    logic [N-1:0]  pending;
    logic [N-1:0]  overrun;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    edge_event_arbiter #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .sig       (sig),
        .en        (en),
        .ovr_clr   (ovr_clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_rise  (evt_rise),
        .pending   (pending),
        .overrun   (overrun)
    );

    // Clock and reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_evt(input int ch, input logic rise);
        logic [W-1:0] e;
        e = {CW'(ch), rise};
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: an accepted handshake must match the queue head.
    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got chan=%0d rise=%0d expected none",
                         evt_chan, evt_rise);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({evt_chan, evt_rise} !== e) begin
                    errors++;
                    $display("FAIL event: got chan=%0d rise=%0d expected chan=%0d rise=%0d",
                             evt_chan, evt_rise, e[W-1:1], e[0]);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        sig       = 4'b1010;
        en        = 4'b1111;
        ovr_clr   = 4'b0000;
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", 32'(evt_valid), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_chan_rise", 32'({evt_chan, evt_rise}), 32'd0);

        // Release with sig=1010 held: the level is never an edge.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("prime_valid", 32'(evt_valid), 32'd0);
            chk("prime_pending", 32'(pending), 32'd0);
        end

        // Channels 0,1,3 toggle together: served in order 0,1,3.
        sig = 4'b0001;
        push_evt(0, 1'b1);
        push_evt(1, 1'b0);
        push_evt(3, 1'b0);
        tick();
        chk("multi_pending", 32'(pending), 32'b1011);
        tick();
        chk("multi_ev0", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd0, 1'b1});
        tick();
        chk("multi_ev1", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd1, 1'b0});
        tick();
        chk("multi_ev3", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd3, 1'b0});
        tick();
        chk("multi_idle", 32'(evt_valid), 32'd0);

        // Single rise on channel 2: valid one clock after it is recorded.
        sig = 4'b0101;
        push_evt(2, 1'b1);
        tick();
        chk("lat_pending", 32'(pending), 32'b0100);
        chk("lat_not_yet", 32'(evt_valid), 32'd0);
        tick();
        chk("lat_event", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd2, 1'b1});
        tick();
        chk("lat_idle", 32'(evt_valid), 32'd0);

        // Stall with channel 1 toggling every cycle.
        evt_ready = 1'b0;
        sig = 4'b0111;
        push_evt(1, 1'b1);
        push_evt(1, 1'b0);
        tick();
        sig = 4'b0101;
        tick();
        chk("stall_first", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd1, 1'b1});
        chk("grant_set_pending", 32'(pending), 32'b0010);
        chk("grant_set_no_ovr", 32'(overrun), 32'd0);
        sig = 4'b0111;
        tick();
        sig = 4'b0101;
        tick();
        chk("stall_hold", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd1, 1'b1});
        chk("ovr_set", 32'(overrun), 32'b0010);
        chk("ovr_pending", 32'(pending), 32'b0010);
        evt_ready = 1'b1;
        tick();
        chk("second_event", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd1, 1'b0});
        chk("second_pending", 32'(pending), 32'd0);
        tick();
        chk("second_idle", 32'(evt_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'b0010);
        ovr_clr = 4'b0010;
        tick();
        ovr_clr = 4'b0000;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Channel 3 disabled while toggling, then re-enabled at a stable level.
        en = 4'b0111;
        sig = 4'b1101;
        tick();
        sig = 4'b0101;
        tick();
        sig = 4'b1101;
        tick();
        tick();
        en = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_quiet_pending", 32'(pending), 32'd0);
            chk("en_quiet_valid", 32'(evt_valid), 32'd0);
        end
        sig = 4'b0101;
        push_evt(3, 1'b0);
        tick();
        tick();
        chk("en_event", 32'({evt_valid, evt_chan, evt_rise}), {29'd0, 1'b1, 2'd3, 1'b0});
        tick();

        // Reset in the middle of a stalled handshake drops everything.
        evt_ready = 1'b0;
        sig = 4'b0010;
        tick();
        tick();
        chk("pre_reset_valid", 32'({evt_valid, evt_chan}), {29'd0, 1'b1, 2'd0});
        chk("pre_reset_pending", 32'(pending), 32'b0110);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(evt_valid), 32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        chk("async_chan_rise", 32'({evt_chan, evt_rise}), 32'd0);
        tick();
        reset = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_valid", 32'(evt_valid), 32'd0);
            chk("post_reset_pending", 32'(pending), 32'd0);
        end
        sig = 4'b0110;
        push_evt(2, 1'b1);

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            tick();
        end
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel dual-edge event controller.
- Watches N synchronous level inputs and detects both rising and falling edges per channel using one dual-edge sampler per channel.
- Queues one pending event per channel and shares a single valid/ready event output between channels using round-robin arbitration.
- Sits between the board-level switch/sensor inputs and any downstream consumer (counter, display, UART logger) that takes one edge event at a time.

Parameters:
- N, 4, number of input channels (2..16).
- CW, $clog2(N), channel index width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- sig  in  N  level inputs, already synchronous to clk.
- en  in  N  per-channel detect enable.
- ovr_clr  in  N  per-channel overrun clear pulse.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event (handshake when evt_valid & evt_ready at posedge).
- evt_chan  out  CW  channel index of the presented event.
- evt_rise  out  1  1 = rising edge, 0 = falling edge.
- pending  out  N  per-channel pending flag (not yet presented).
- overrun  out  N  sticky flag: an edge arrived while the channel was already pending.

Behaviour:
- Reset (reset=0, asynchronous): prev=0, primed=0, pend=0, pol=0, overrun=0, evt_valid=0, evt_chan=0, evt_rise=0, rr_last=N-1.
- Priming: on the first posedge after reset release, each sampler loads prev<=sig[i], sets primed<=1 and raises no edge. The input level at reset release is therefore never reported as an edge.
- Sampler, every posedge: prev[i]<=sig[i].
- Edge detect: edge[i] = primed[i] & en[i] & (sig[i] != prev[i]).
- Recording: if edge[i] at posedge k, then pend[i]<=1 and pol[i]<=sig[i], visible after posedge k.
- Overrun: if edge[i] & pend[i] & not granted this cycle, then overrun[i]<=1 and pol[i] updates to the newest polarity. Only one event is retained per channel.
- Enable off (en[i]=0): no new edges are recorded, but prev keeps tracking. An existing pend[i] is still delivered. Re-enabling does not create an edge from the level difference at that moment.
- Output slot is free when !evt_valid | evt_ready.
- Arbitration, when the slot is free and |pend:
  - Search channels rr_last+1 .. rr_last+N (mod N); the first pending channel g wins.
  - Register evt_valid<=1, evt_chan<=g, evt_rise<=pol[g]; clear pend[g]; rr_last<=g.
- Slot free and no pend: evt_valid<=0.
- Latency: a change sampled at posedge k with an idle output gives evt_valid=1 after posedge k+1.
  - Back-to-back throughput is one event per clock while evt_ready stays high.
- Stall: while evt_valid & !evt_ready, evt_chan and evt_rise are held stable and no grant occurs.
- Same-cycle grant and new edge on the same channel: the set wins. pend stays 1 with the new pol, and overrun is not set, because the old event was consumed.
- ovr_clr[i] clears overrun[i]; a simultaneous overrun set wins over the clear.
- pending = pend, overrun = overrun. Both are registered outputs.
- Reset asserted mid-handshake drops all queued events immediately; the consumer sees evt_valid fall asynchronously.

Decomposition:
- Shared package edge_pkg:
  - EVT_RISE=1'b1 and EVT_FALL=1'b0 constants.
  - Channel-index width function.
- Sub-module dual_edge_sampler, instantiated N times:
  - Inputs: clk, reset, sig, en.
  - Outputs: edge, level.
  - Holds prev and primed.
- Arbiter, pend/pol/overrun registers and output register live in edge_event_arbiter.

Test Plan:
- Reset release with sig=4'b1010, held 5 cycles: evt_valid stays 0; pending=0.
- sig[2] 0→1 sampled at posedge k with evt_ready=1: after posedge k+1, evt_valid=1, evt_chan=2, evt_rise=1. Next cycle evt_valid=0.
- sig[0], sig[1] and sig[3] toggle in the same cycle with evt_ready=1 and rr_last=N-1: events appear in channel order 0, 1, 3 on consecutive cycles.
- evt_ready=0 and sig[1] toggles 0→1→0 on two cycles:
  - Output holds the first event with evt_rise=1.
  - overrun[1]=1, pend[1]=1 with pol=0.
  - After ready, a second event with evt_chan=1, evt_rise=0.
  - Then pulse ovr_clr[1]: overrun[1]=0.
- en[3]=0 while sig[3] toggles, then en[3]=1 with sig stable: no event for channel 3. The next toggle is reported normally.
- Assert reset while evt_valid=1 and pending=4'b0110: all outputs go to 0 immediately. No event is reported after release until a new edge occurs.
